// File: rtl/divider_arbiter.sv
// divider_arbiter: shares one serial Divider between two requesters, round-robin.
// Define DIV_ARB_TIMEOUT_EN to add a result watchdog (TIMEOUT_CYC cycles).
//
// state | meaning
// IDLE  | arbitrate and accept the winner's operand word
// SEND  | stream the latched word to the Divider, MS nibble first
// WAIT  | wait for the first result bit
// RECV  | collect remaining result bits, stalling on gaps
// RESP  | one-cycle response pulse to the granted requester
module divider_arbiter #(
    parameter int NIB_CNT     = 2,
    parameter int RES_BITS    = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    input  logic [4*NIB_CNT-1:0] req_data0,
    input  logic [4*NIB_CNT-1:0] req_data1,
    output logic [1:0]           req_ready,
    output logic [1:0]           rsp_valid,
    output logic [RES_BITS-1:0]  rsp_data,
    output logic                 rsp_err,
    output logic                 div_in_valid,
    output logic [3:0]           div_in_data,
    input  logic                 div_out_valid,
    input  logic                 div_out_data
);
    localparam int DW = 4 * NIB_CNT;
    localparam int NW = (NIB_CNT > 1) ? $clog2(NIB_CNT) : 1;
    localparam int BW = (RES_BITS > 1) ? $clog2(RES_BITS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_RESP} state_t;

    state_t              r_state;
    logic                r_rr;
    logic                r_grant;
    logic [DW-1:0]       r_word;
    logic [NW-1:0]       r_nib;
    logic [BW-1:0]       r_bit;
    logic [RES_BITS-1:0] r_shift;
    logic [RES_BITS-1:0] r_rsp_data;
    logic [1:0]          r_rsp_valid;

    logic                w_grant;
    logic                w_accept;
    logic [DW-1:0]       w_req_data;
    logic [1:0]          w_grant_oh;
    logic [RES_BITS-1:0] w_shift_cap;

`ifdef DIV_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TW-1:0] r_wdog;
    logic          r_rsp_err;
    assign rsp_err = r_rsp_err;
`else
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = TIMEOUT_CYC;
    assign rsp_err          = 1'b0;
`endif

    // rr_ptr side wins if it is asking, otherwise the other side
    assign w_grant    = req_valid[r_rr] ? r_rr : ~r_rr;
    assign w_accept   = (r_state == S_IDLE) && (req_valid != 2'b00);
    assign w_req_data = w_grant ? req_data1 : req_data0;
    assign w_grant_oh = r_grant ? 2'b10 : 2'b01;

    assign req_ready    = w_accept ? (w_grant ? 2'b10 : 2'b01) : 2'b00;
    assign div_in_valid = (r_state == S_SEND);
    assign div_in_data  = (r_state == S_SEND) ? r_word[DW-1 -: 4] : 4'h0;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;

    // Bits land at their final position, so a partial result has zeros below
    always_comb begin
        w_shift_cap        = r_shift;
        w_shift_cap[r_bit] = div_out_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rr        <= 1'b0;
            r_grant     <= 1'b0;
            r_word      <= '0;
            r_nib       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_rsp_data  <= '0;
            r_rsp_valid <= 2'b00;
`ifdef DIV_ARB_TIMEOUT_EN
            r_wdog      <= '0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            r_rsp_valid <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_word  <= w_req_data;
                        r_grant <= w_grant;
                        r_rr    <= ~w_grant;
                        r_nib   <= NW'(NIB_CNT - 1);
                        r_shift <= '0;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    r_word <= r_word << 4;
                    if (r_nib == '0) begin
                        r_bit   <= BW'(RES_BITS - 1);
`ifdef DIV_ARB_TIMEOUT_EN
                        r_wdog  <= TW'(TIMEOUT_CYC - 1);
`endif
                        r_state <= S_WAIT;
                    end else begin
                        r_nib <= r_nib - 1'b1;
                    end
                end
                S_WAIT, S_RECV: begin
                    if (div_out_valid) begin
                        r_shift <= w_shift_cap;
`ifdef DIV_ARB_TIMEOUT_EN
                        r_wdog  <= TW'(TIMEOUT_CYC - 1);
`endif
                        if (r_bit == '0) begin
                            r_rsp_data  <= w_shift_cap;
                            r_rsp_valid <= w_grant_oh;
`ifdef DIV_ARB_TIMEOUT_EN
                            r_rsp_err   <= 1'b0;
`endif
                            r_state     <= S_RESP;
                        end else begin
                            r_bit   <= r_bit - 1'b1;
                            r_state <= S_RECV;
                        end
                    end
`ifdef DIV_ARB_TIMEOUT_EN
                    else if (r_wdog == '0) begin
                        r_rsp_data  <= r_shift;
                        r_rsp_valid <= w_grant_oh;
                        r_rsp_err   <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_wdog <= r_wdog - 1'b1;
                    end
`endif
                end
                S_RESP: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
